reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Architectural register file that sits directly upstream of the ALU and drives its src1/src2 operands.
- Provides two combinational read ports with same-cycle write-back bypass and one synchronous write port.
- Holds a per-register busy scoreboard so the issue logic can stall an instruction whose operands or destination are still pending from an earlier multi-cycle producer.
- Register 0 is hardwired to zero.

Parameters:
DATA_W  32  register and operand width
ADDR_W  5  register index width; NUM_REGS = 2**ADDR_W
CNT_W  6  width of outstanding-write counter; must hold NUM_REGS

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  asynchronous, active-high reset
rs1_addr_i  input  ADDR_W  read port 1 index
rs2_addr_i  input  ADDR_W  read port 2 index
rs1_data_o  output  DATA_W  read port 1 data, to ALU src1
rs2_data_o  output  DATA_W  read port 2 data, to ALU src2
we_i  input  1  write-back enable
wr_addr_i  input  ADDR_W  write-back index
wr_data_i  input  DATA_W  write-back data
issue_valid_i  input  1  an instruction using rs1/rs2 requests issue this cycle
issue_wr_i  input  1  issuing instruction will write a destination register
issue_rd_i  input  ADDR_W  destination index of issuing instruction
stall_o  output  1  issue blocked this cycle
pending_o  output  CNT_W  number of busy registers

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset state: while rst_i=1, all registers are 0, all busy bits are 0, and pending_o=0.
  - Read outputs are combinational, so they show 0 during reset unless a bypass is active.
  - Reset asserted mid-operation discards all in-flight scoreboard state immediately.
- Write:
  - At posedge with we_i=1 and wr_addr_i!=0, the register at wr_addr_i takes wr_data_i.
  - Writes to index 0 are ignored. Register 0 always reads 0 and its busy bit is never set.
- Read (combinational, zero latency), evaluated independently per port:
  - Address 0 returns 0.
  - Otherwise, if we_i=1 and wr_addr_i equals the read address, the port returns wr_data_i (write-first bypass).
  - Otherwise the port returns the stored value.
- Scoreboard hazard terms:
  - clr(i) = we_i && wr_addr_i==i && i!=0.
  - hz1 = busy[rs1_addr_i] && !clr(rs1_addr_i).
  - hz2 = busy[rs2_addr_i] && !clr(rs2_addr_i).
  - waw = issue_wr_i && busy[issue_rd_i] && !clr(issue_rd_i).
- stall_o = issue_valid_i && (hz1 || hz2 || waw). This is purely combinational with no registered delay.
- Accept: accept = issue_valid_i && !stall_o.
- Busy-bit update at posedge, per register:
  - A register is set if accept && issue_wr_i && issue_rd_i==i && i!=0.
  - Otherwise it is cleared if clr(i).
  - If set and clear hit the same index in the same cycle, set wins (the new producer owns the register). The write data still lands in the register.
- Writing a register whose busy bit is 0 is legal: data is stored and the busy bit stays 0.
- pending_o is registered:
  - +1 on a set of a previously clear bit.
  - −1 on a clear of a previously set bit.
  - Net 0 when both occur on the same index.
  - It must always equal the popcount of the busy bits and can never wrap. Max is NUM_REGS−1, since index 0 is excluded.
- No internal FSM beyond the scoreboard. Issue and write-back may occur every cycle with no bubbles.

Test Plan:
1. Reset, then read: assert rst_i, write x5=0x1234 at posedge, release reset, read rs1=5 → rs1_data_o=0x00000000 (the write during reset is lost) and pending_o=0.
2. Write then read: we_i=1, wr_addr_i=7, wr_data_i=0xDEADBEEF for 1 cycle; next cycle rs1=7, rs2=0 → rs1_data_o=0xDEADBEEF, rs2_data_o=0.
3. Bypass and x0:
   - same cycle we_i=1, wr_addr_i=3, wr_data_i=0x55, rs2=3 → rs2_data_o=0x55 before the clock edge;
   - write x0=0xFFFFFFFF → reads of x0 stay 0.
4. RAW stall:
   - issue_valid_i=1, issue_wr_i=1, issue_rd_i=9 accepted → pending_o=1;
   - next issue with rs1=9 → stall_o=1 until a cycle with we_i=1, wr_addr_i=9;
   - in that cycle stall_o=0 and rs1_data_o=wr_data_i;
   - pending_o returns to 0.
5. WAW and simultaneous set/clear:
   - x4 busy; issue with rd=4 while we_i=1, wr_addr_i=4 → stall_o=0, accepted, busy[4] stays 1, pending_o unchanged at 1;
   - the same issue without the write-back → stall_o=1.
6. Async reset mid-flight: busy bits x1..x3 set (pending_o=3); assert rst_i between clock edges → pending_o=0 and stall_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/reg_file_sb.sv
// Architectural register file with write-first bypass and a per-register busy
// scoreboard that tells the issue stage when to hold an instruction.
module reg_file_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  output logic [DATA_W-1:0] rs1_data_o,
  output logic [DATA_W-1:0] rs2_data_o,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              issue_valid_i,
  input  logic              issue_wr_i,
  input  logic [ADDR_W-1:0] issue_rd_i,
  output logic              stall_o,
  output logic [CNT_W-1:0]  pending_o
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0] clr_vec, set_vec;
  logic [CNT_W-1:0]    pending_q, pending_d;
  logic                hz1, hz2, waw, accept, inc, dec;

  // A write-back in flight this cycle releases its register right away, so a
  // consumer waiting on it issues in the same cycle and picks up the bypass.
  always_comb begin
    clr_vec = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      clr_vec[i] = we_i && (wr_addr_i == ADDR_W'(i));
    end
  end

  assign rs1_data_o = (rs1_addr_i == '0) ? '0 :
                      (we_i && (wr_addr_i == rs1_addr_i)) ? wr_data_i : regs_q[rs1_addr_i];
  assign rs2_data_o = (rs2_addr_i == '0) ? '0 :
                      (we_i && (wr_addr_i == rs2_addr_i)) ? wr_data_i : regs_q[rs2_addr_i];

  // Issue handshake: issue_valid_i is the request, stall_o the refusal; an
  // instruction is taken on any cycle with issue_valid_i=1 and stall_o=0.
  assign hz1     = busy_q[rs1_addr_i] && !clr_vec[rs1_addr_i];
  assign hz2     = busy_q[rs2_addr_i] && !clr_vec[rs2_addr_i];
  assign waw     = issue_wr_i && busy_q[issue_rd_i] && !clr_vec[issue_rd_i];
  assign stall_o = issue_valid_i && (hz1 || hz2 || waw);
  assign accept  = issue_valid_i && !stall_o;

  always_comb begin
    set_vec = '0;
    if (accept && issue_wr_i && (issue_rd_i != '0)) begin
      set_vec[issue_rd_i] = 1'b1;
    end
  end

  // Set beats clear on the same index: the newly issued producer owns it.
  assign busy_d    = (busy_q & ~clr_vec) | set_vec;
  assign inc       = |(set_vec & ~busy_q);
  assign dec       = |(busy_q & clr_vec & ~set_vec);
  assign pending_d = pending_q + CNT_W'(inc) - CNT_W'(dec);
  assign pending_o = pending_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (wr_addr_i != '0)) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q    <= '0;
      pending_q <= '0;
    end else begin
      busy_q    <= busy_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed scenarios plus random traffic, all checked
// against an array-based model of the register file and its busy set.
module tb_reg_file_sb;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i, wr_addr_i, issue_rd_i;
  logic [31:0] rs1_data_o, rs2_data_o, wr_data_i;
  logic        we_i, issue_valid_i, issue_wr_i, stall_o;
  logic [5:0]  pending_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_mem  [32];
  bit          m_busy [32];

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .CNT_W(6)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .we_i(we_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .issue_valid_i(issue_valid_i), .issue_wr_i(issue_wr_i), .issue_rd_i(issue_rd_i),
    .stall_o(stall_o), .pending_o(pending_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return '0;
    if (we_i && wr_addr_i == a) return wr_data_i;
    return m_mem[a];
  endfunction

  function automatic bit m_still_busy(input logic [4:0] a);
    return m_busy[a] && !(we_i && wr_addr_i == a && a != 0);
  endfunction

  function automatic bit m_stall();
    return issue_valid_i && (m_still_busy(rs1_addr_i) || m_still_busy(rs2_addr_i) ||
                             (issue_wr_i && m_still_busy(issue_rd_i)));
  endfunction

  function automatic int m_pending();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  // ---------------- driver ----------------
  task automatic idle_inputs();
    rs1_addr_i = '0; rs2_addr_i = '0; we_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
    issue_valid_i = 1'b0; issue_wr_i = 1'b0; issue_rd_i = '0;
  endtask

  // One clock: check the combinational outputs mid-cycle, advance the model on
  // the edge, then check the registered pending count just after it.
  task automatic step();
    bit acc;
    @(negedge clk_i);
    check("rs1_data", rs1_data_o, m_read(rs1_addr_i));
    check("rs2_data", rs2_data_o, m_read(rs2_addr_i));
    check("stall", {31'b0, stall_o}, {31'b0, m_stall()});
    acc = issue_valid_i && !m_stall();
    @(posedge clk_i);
    if (rst_i) begin
      m_reset();
    end else begin
      if (we_i && wr_addr_i != 0) begin
        m_mem[wr_addr_i]  = wr_data_i;
        m_busy[wr_addr_i] = 1'b0;
      end
      if (acc && issue_wr_i && issue_rd_i != 0) m_busy[issue_rd_i] = 1'b1;
    end
    #1;
    check("pending", {26'b0, pending_o}, 32'(m_pending()));
  endtask

  initial begin
    idle_inputs();
    rst_i = 1'b1;
    m_reset();

    // Write during reset is lost.
    we_i = 1'b1; wr_addr_i = 5'd5; wr_data_i = 32'h1234;
    step();
    rst_i = 1'b0; we_i = 1'b0; rs1_addr_i = 5'd5;
    step();
    check("t1_x5_after_reset", rs1_data_o, 32'h0);
    check("t1_pending", {26'b0, pending_o}, 32'd0);

    // Write then read.
    we_i = 1'b1; wr_addr_i = 5'd7; wr_data_i = 32'hDEADBEEF; rs1_addr_i = 5'd0;
    step();
    we_i = 1'b0; rs1_addr_i = 5'd7; rs2_addr_i = 5'd0;
    step();
    check("t2_x7", rs1_data_o, 32'hDEADBEEF);
    check("t2_x0", rs2_data_o, 32'h0);

    // Bypass, then x0 write ignored.
    we_i = 1'b1; wr_addr_i = 5'd3; wr_data_i = 32'h55; rs2_addr_i = 5'd3;
    #1 check("t3_bypass", rs2_data_o, 32'h55);
    step();
    wr_addr_i = 5'd0; wr_data_i = 32'hFFFFFFFF; rs1_addr_i = 5'd0; rs2_addr_i = 5'd0;
    #1 check("t3_x0_bypass", rs1_data_o, 32'h0);
    step();
    we_i = 1'b0;
    step();
    check("t3_x0_read", rs2_data_o, 32'h0);

    // RAW stall released by the matching write-back.
    issue_valid_i = 1'b1; issue_wr_i = 1'b1; issue_rd_i = 5'd9;
    step();
    check("t4_pending1", {26'b0, pending_o}, 32'd1);
    issue_wr_i = 1'b0; rs1_addr_i = 5'd9;
    for (int k = 0; k < 3; k++) begin
      #1 check("t4_raw_stall", {31'b0, stall_o}, 32'd1);
      step();
    end
    we_i = 1'b1; wr_addr_i = 5'd9; wr_data_i = 32'hA5A50009;
    #1 check("t4_release", {31'b0, stall_o}, 32'd0);
    check("t4_bypass", rs1_data_o, 32'hA5A50009);
    step();
    idle_inputs();
    step();
    check("t4_pending0", {26'b0, pending_o}, 32'd0);

    // WAW with simultaneous set/clear on x4.
    issue_valid_i = 1'b1; issue_wr_i = 1'b1; issue_rd_i = 5'd4;
    step();
    we_i = 1'b1; wr_addr_i = 5'd4; wr_data_i = 32'h44;
    #1 check("t5_waw_cleared", {31'b0, stall_o}, 32'd0);
    step();
    check("t5_pending_same", {26'b0, pending_o}, 32'd1);
    we_i = 1'b0;
    #1 check("t5_waw_stall", {31'b0, stall_o}, 32'd1);
    step();
    issue_valid_i = 1'b0; we_i = 1'b1; wr_addr_i = 5'd4; wr_data_i = 32'h4444;
    step();
    idle_inputs();

    // Fill every architectural register, then drain.
    issue_valid_i = 1'b1; issue_wr_i = 1'b1;
    for (int r = 1; r < 32; r++) begin
      issue_rd_i = 5'(r);
      step();
    end
    check("fill_pending_max", {26'b0, pending_o}, 32'd31);
    issue_valid_i = 1'b0; we_i = 1'b1;
    for (int r = 1; r < 32; r++) begin
      wr_addr_i = 5'(r); wr_data_i = $urandom;
      step();
    end
    check("drain_pending0", {26'b0, pending_o}, 32'd0);
    idle_inputs();

    // Random traffic concentrated on a few registers to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      rs1_addr_i    = 5'($urandom_range(0, 7));
      rs2_addr_i    = 5'($urandom_range(0, 7));
      we_i          = 1'($urandom_range(0, 1));
      wr_addr_i     = 5'($urandom_range(0, 7));
      wr_data_i     = $urandom;
      issue_valid_i = 1'($urandom_range(0, 1));
      issue_wr_i    = 1'($urandom_range(0, 1));
      issue_rd_i    = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      step();
    end

    // Asynchronous reset between edges.
    idle_inputs();
    rst_i = 1'b1; m_reset();
    step();
    rst_i = 1'b0;
    issue_valid_i = 1'b1; issue_wr_i = 1'b1;
    for (int r = 1; r <= 3; r++) begin
      issue_rd_i = 5'(r);
      step();
    end
    check("t6_pending3", {26'b0, pending_o}, 32'd3);
    issue_wr_i = 1'b0; rs1_addr_i = 5'd1;
    #1 check("t6_stall_before", {31'b0, stall_o}, 32'd1);
    #1 rst_i = 1'b1; m_reset();
    #1 check("t6_async_pending", {26'b0, pending_o}, 32'd0);
    check("t6_async_stall", {31'b0, stall_o}, 32'd0);
    step();
    rst_i = 1'b0; idle_inputs();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
